// File: rtl/fpmul_pipe_harness.sv
// Handshaked, STAGES-deep result pipeline around a combinational binary32 multiplier core.
// Optional sticky exception-flag accumulator enabled by defining FPMUL_STICKY_FLAGS_EN.
`ifndef WIDTH
`define WIDTH 32
`endif
`ifndef WCONTROL
`define WCONTROL 2
`endif
`ifndef WFLAG
`define WFLAG 4
`endif

// Binary32 multiply, flush-to-zero for subnormal inputs and tiny results.
// control: 0 nearest-even, 1 toward zero, 2 toward +inf, 3 toward -inf.
// flagout: {invalid, overflow, underflow, inexact}.
module fpmul (
  input  logic [`WIDTH-1:0]    a,
  input  logic [`WIDTH-1:0]    b,
  input  logic [`WCONTROL-1:0] control,
  output logic [`WIDTH-1:0]    out,
  output logic [`WFLAG-1:0]    flagout
);
  logic        sa, sb, sgn;
  logic [7:0]  ea, eb;
  logic [22:0] fa, fb;
  assign {sa, ea, fa} = a;
  assign {sb, eb, fb} = b;
  assign sgn = sa ^ sb;

  logic a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, inv_mul, snan;
  assign a_zero  = (ea == 8'd0);
  assign b_zero  = (eb == 8'd0);
  assign a_inf   = (ea == 8'hFF) && (fa == 23'd0);
  assign b_inf   = (eb == 8'hFF) && (fb == 23'd0);
  assign a_nan   = (ea == 8'hFF) && (fa != 23'd0);
  assign b_nan   = (eb == 8'hFF) && (fb != 23'd0);
  assign inv_mul = (a_inf && b_zero) || (a_zero && b_inf);
  assign snan    = (a_nan && !fa[22]) || (b_nan && !fb[22]);

  logic [47:0] prod;
  assign prod = {1'b1, fa} * {1'b1, fb};

  logic signed [9:0] e_norm, e_fin;
  assign e_norm = $signed({2'b00, ea}) + $signed({2'b00, eb}) - 10'sd127
                + $signed({9'd0, prod[47]});

  logic [22:0] frac;
  logic        guard, sticky, round_up;
  always_comb begin
    if (prod[47]) begin
      frac   = prod[46:24];
      guard  = prod[23];
      sticky = |prod[22:0];
    end else begin
      frac   = prod[45:23];
      guard  = prod[22];
      sticky = |prod[21:0];
    end
    case (control)
      2'd0:    round_up = guard && (sticky || frac[0]);
      2'd2:    round_up = !sgn && (guard || sticky);
      2'd3:    round_up = sgn && (guard || sticky);
      default: round_up = 1'b0;
    endcase
  end

  // A carry out of the fraction leaves it all-zero and bumps the exponent.
  logic [23:0] frac_r;
  logic        ovf_inf;
  assign frac_r  = {1'b0, frac} + {23'd0, round_up};
  assign e_fin   = e_norm + $signed({9'd0, frac_r[23]});
  assign ovf_inf = (control == 2'd0) || (control == 2'd2 && !sgn) || (control == 2'd3 && sgn);

  always_comb begin
    out     = '0;
    flagout = '0;
    if (a_nan || b_nan || inv_mul) begin
      out        = 32'h7FC0_0000;
      flagout[3] = inv_mul || snan;
    end else if (a_inf || b_inf) begin
      out = {sgn, 8'hFF, 23'd0};
    end else if (a_zero || b_zero) begin
      out = {sgn, 31'd0};
    end else if (e_fin >= 10'sd255) begin
      flagout[2] = 1'b1;
      flagout[0] = 1'b1;
      out        = ovf_inf ? {sgn, 8'hFF, 23'd0} : {sgn, 8'hFE, 23'h7F_FFFF};
    end else if (e_fin <= 10'sd0) begin
      flagout[1] = 1'b1;
      flagout[0] = 1'b1;
      out        = {sgn, 31'd0};
    end else begin
      flagout[0] = guard || sticky;
      out        = {sgn, e_fin[7:0], frac_r[22:0]};
    end
  end
endmodule

module fpmul_pipe_harness #(
  parameter int WIDTH  = `WIDTH,
  parameter int WCTRL  = `WCONTROL,
  parameter int WFLG   = `WFLAG,
  parameter int STAGES = 1,
  parameter int CNTW   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WCTRL-1:0] control,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic [WFLG-1:0]  flagout,
  output logic             busy,
  output logic [CNTW-1:0]  txn_count
`ifdef FPMUL_STICKY_FLAGS_EN
  ,
  input  logic             sticky_clr,
  output logic [WFLG-1:0]  sticky_flags
`endif
);
  // vld_pipe[0] is the input register, vld_pipe[STAGES] the output register.
  logic [STAGES:0]            vld_pipe;
  logic [WIDTH-1:0]           a_q, b_q;
  logic [WCTRL-1:0]           ctl_q;
  logic [STAGES:1][WIDTH-1:0] prod_pipe;
  logic [STAGES:1][WFLG-1:0]  flg_pipe;
  logic [WIDTH-1:0]           core_out;
  logic [WFLG-1:0]            core_flg;
  logic                       advance, handoff;

  fpmul u_core (.a(a_q), .b(b_q), .control(ctl_q), .out(core_out), .flagout(core_flg));

  // Whole-pipe stall: nothing moves while the output beat waits.
  assign advance   = !(vld_pipe[STAGES] && !out_ready);
  assign handoff   = vld_pipe[STAGES] && out_ready;
  assign in_ready  = advance;
  assign out_valid = vld_pipe[STAGES];
  assign out       = prod_pipe[STAGES];
  assign flagout   = flg_pipe[STAGES];
  assign busy      = |vld_pipe;

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_pipe  <= '0;
      a_q       <= '0;
      b_q       <= '0;
      ctl_q     <= '0;
      prod_pipe <= '0;
      flg_pipe  <= '0;
      txn_count <= '0;
    end else begin
      if (advance) begin
        vld_pipe <= {vld_pipe[STAGES-1:0], in_valid};
        if (in_valid) begin
          a_q   <= a;
          b_q   <= b;
          ctl_q <= control;
        end
        prod_pipe[1] <= core_out;
        flg_pipe[1]  <= core_flg;
        for (int i = 2; i <= STAGES; i++) begin
          prod_pipe[i] <= prod_pipe[i-1];
          flg_pipe[i]  <= flg_pipe[i-1];
        end
      end
      if (handoff) txn_count <= txn_count + CNTW'(1);
    end
  end

`ifdef FPMUL_STICKY_FLAGS_EN
  // A clear coinciding with a handoff keeps that beat's flags.
  always_ff @(posedge clk) begin
    if (reset)           sticky_flags <= '0;
    else if (sticky_clr) sticky_flags <= handoff ? flagout : '0;
    else if (handoff)    sticky_flags <= sticky_flags | flagout;
  end
`endif
endmodule

// File: tb/tb_fpmul_pipe_harness.sv
// Bench for fpmul_pipe_harness: a STAGES=1/CNTW=16 and a STAGES=3/CNTW=4 instance share stimulus,
// each scored against an arithmetic multiply model and a latency/flow-control scoreboard.
module tb_fpmul_pipe_harness;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, in_valid, out_ready;
  logic [31:0] a, b;
  logic [1:0]  control;
  logic        rdy1, ov1, busy1, rdy3, ov3, busy3;
  logic [31:0] out1, out3;
  logic [3:0]  flg1, flg3;
  logic [15:0] cnt1;
  logic [3:0]  cnt3;
`ifdef FPMUL_STICKY_FLAGS_EN
  logic        sticky_clr;
  logic [3:0]  stk1, stk3;
`endif

  fpmul_pipe_harness dut1 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy1), .a(a), .b(b),
    .control(control), .out_valid(ov1), .out_ready(out_ready), .out(out1), .flagout(flg1),
    .busy(busy1), .txn_count(cnt1)
`ifdef FPMUL_STICKY_FLAGS_EN
    , .sticky_clr(sticky_clr), .sticky_flags(stk1)
`endif
  );

  fpmul_pipe_harness #(.STAGES(3), .CNTW(4)) dut3 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy3), .a(a), .b(b),
    .control(control), .out_valid(ov3), .out_ready(out_ready), .out(out3), .flagout(flg3),
    .busy(busy3), .txn_count(cnt3)
`ifdef FPMUL_STICKY_FLAGS_EN
    , .sticky_clr(sticky_clr), .sticky_flags(stk3)
`endif
  );

  typedef struct {
    logic [35:0] r;   // {flags, product}
    int          cd;  // advancing edges still needed before the beat is visible
  } ent_t;

  ent_t        q[2][$];
  int          m_cnt[2];
  logic [3:0]  m_stk[2];
  logic        acc_q[2];
  int          checks = 0, failures = 0;

  function automatic int stg(input int i);
    return (i == 0) ? 1 : 3;
  endfunction

  function automatic int cmod(input int i);
    return (i == 0) ? 65536 : 16;
  endfunction

  task automatic chk(input string tag, input logic [35:0] obs, input logic [35:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Exact product rounded to 24 significant bits; subnormals flush to zero.
  function automatic logic [35:0] ref_mul(input logic [31:0] x, input logic [31:0] y, input logic [1:0] rm);
    logic       sg, xz, yz, xi, yi, xn, yn, up;
    int         ex, ey, k, sh, e;
    longint     p, sig, rem, half;
    logic [3:0] f;
    logic [31:0] r;
    sg = x[31] ^ y[31];
    ex = int'(x[30:23]);
    ey = int'(y[30:23]);
    xz = (ex == 0); yz = (ey == 0);
    xi = (ex == 255) && (x[22:0] == 0); yi = (ey == 255) && (y[22:0] == 0);
    xn = (ex == 255) && (x[22:0] != 0); yn = (ey == 255) && (y[22:0] != 0);
    f = 4'd0;
    if (xn || yn || (xi && yz) || (xz && yi)) begin
      f[3] = (xi && yz) || (xz && yi) || (xn && !x[22]) || (yn && !y[22]);
      r = 32'h7FC0_0000;
    end else if (xi || yi) r = {sg, 8'hFF, 23'd0};
    else if (xz || yz) r = {sg, 31'd0};
    else begin
      p = (longint'(1 << 23) + longint'(x[22:0])) * (longint'(1 << 23) + longint'(y[22:0]));
      k = 0;
      while ((p >> (k + 1)) != 0) k++;
      sh   = k - 23;
      sig  = p >> sh;
      rem  = p - (sig << sh);
      half = longint'(1) << (sh - 1);
      e    = k + ex + ey - 173;
      case (rm)
        2'd0:    up = (rem > half) || (rem == half && sig[0]);
        2'd2:    up = !sg && rem != 0;
        2'd3:    up = sg && rem != 0;
        default: up = 1'b0;
      endcase
      if (up) sig = sig + 1;
      if (sig == (longint'(1) << 24)) begin sig = longint'(1) << 23; e++; end
      if (e >= 255) begin
        f = 4'b0101;
        r = (rm == 0 || (rm == 2 && !sg) || (rm == 3 && sg)) ? {sg, 8'hFF, 23'd0} : {sg, 8'hFE, 23'h7F_FFFF};
      end else if (e <= 0) begin
        f = 4'b0011;
        r = {sg, 31'd0};
      end else begin
        f[0] = (rem != 0);
        r = {sg, 8'(e), 23'(sig)};
      end
    end
    return {f, r};
  endfunction

  function automatic logic [31:0] i2f(input int n);
    int k = 0;
    while ((n >> (k + 1)) != 0) k++;
    return {1'b0, 8'(127 + k), 23'(longint'(n) << (23 - k))};
  endfunction

  function automatic logic [31:0] rnd_op();
    case ($urandom_range(0, 15))
      0:       return 32'h0000_0000;
      1:       return 32'h7F80_0000;
      2:       return 32'h7FC0_0000;
      3:       return 32'h7F80_0001;
      4:       return {1'($urandom), 8'd254, 23'($urandom)};
      5:       return {1'($urandom), 8'd1, 23'($urandom)};
      default: return {1'($urandom), 8'($urandom_range(100, 154)), 23'($urandom)};
    endcase
  endfunction

  // One clock: check outputs at the falling edge, then advance the model on the rising edge.
  task automatic tick();
    logic       ov[2], rdy[2], bz[2], adv[2], ho[2], e_ov;
    logic [35:0] res[2];
    int         cn[2];
    logic [3:0] fl;
`ifdef FPMUL_STICKY_FLAGS_EN
    logic [3:0] stk[2];
`endif
    @(negedge clk);
    ov[0] = ov1; rdy[0] = rdy1; bz[0] = busy1; res[0] = {flg1, out1}; cn[0] = int'(cnt1);
    ov[1] = ov3; rdy[1] = rdy3; bz[1] = busy3; res[1] = {flg3, out3}; cn[1] = int'(cnt3);
`ifdef FPMUL_STICKY_FLAGS_EN
    stk[0] = stk1; stk[1] = stk3;
`endif
    for (int i = 0; i < 2; i++) begin
      e_ov   = (q[i].size() > 0) && (q[i][0].cd == 0);
      adv[i] = !(e_ov && !out_ready);
      ho[i]  = e_ov && out_ready;
      if (!reset) begin
        chk($sformatf("out_valid_s%0d", stg(i)), 36'(ov[i]), 36'(e_ov));
        chk($sformatf("in_ready_s%0d", stg(i)), 36'(rdy[i]), 36'(adv[i]));
        chk($sformatf("busy_s%0d", stg(i)), 36'(bz[i]), 36'(q[i].size() != 0));
        chk($sformatf("txn_count_s%0d", stg(i)), 36'(cn[i]), 36'(m_cnt[i]));
        if (e_ov) chk($sformatf("result_s%0d", stg(i)), res[i], q[i][0].r);
`ifdef FPMUL_STICKY_FLAGS_EN
        chk($sformatf("sticky_s%0d", stg(i)), 36'(stk[i]), 36'(m_stk[i]));
`endif
      end
    end
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      if (reset) begin
        q[i].delete();
        m_cnt[i] = 0;
        m_stk[i] = 4'd0;
        acc_q[i] = 1'b0;
      end else begin
        acc_q[i] = in_valid && adv[i];
        fl = 4'd0;
        if (ho[i]) begin
          fl = q[i][0].r[35:32];
          m_cnt[i] = (m_cnt[i] + 1) % cmod(i);
          void'(q[i].pop_front());
        end
`ifdef FPMUL_STICKY_FLAGS_EN
        if (sticky_clr) m_stk[i] = fl;
        else            m_stk[i] = m_stk[i] | fl;
`endif
        if (adv[i])
          for (int k = 0; k < q[i].size(); k++) begin
            ent_t t = q[i][k];
            if (t.cd > 0) t.cd--;
            q[i][k] = t;
          end
        if (acc_q[i]) q[i].push_back('{ref_mul(a, b, control), stg(i)});
      end
    end
    #1;
  endtask

  initial begin
    int base, n;
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; control = '0;
`ifdef FPMUL_STICKY_FLAGS_EN
    sticky_clr = 1'b0;
`endif
    repeat (2) tick();
    chk("rst_out_valid", 36'(ov1), 36'(0));
    chk("rst_busy", 36'(busy1), 36'(0));
    chk("rst_in_ready", 36'(rdy1), 36'(1));
    chk("rst_out", 36'(out1), 36'(0));
    chk("rst_flagout", 36'(flg1), 36'(0));
    chk("rst_txn", 36'(cnt1), 36'(0));
    chk("rst_out_s3", 36'({ov3, busy3, out3}), 36'(0));
    reset = 1'b0;
    tick();

    // 2.0 x 3.0, one beat
    a = 32'h4000_0000; b = 32'h4040_0000; control = 2'd0; in_valid = 1'b1;
    tick();
    chk("basic_accept", 36'(acc_q[0]), 36'(1));
    in_valid = 1'b0;
    chk("basic_lat_c1", 36'(ov1), 36'(0));
    tick();
    chk("basic_lat_c2", 36'(ov1), 36'(1));
    chk("basic_out", 36'(out1), 36'(32'h40C0_0000));
    chk("basic_flags", 36'(flg1), 36'(0));
    repeat (4) tick();
    chk("basic_txn", 36'(cnt1), 36'(1));
    chk("basic_busy_fall", 36'(busy1), 36'(0));

    // 20 back-to-back beats (i+1.0) x 2.0
    base = m_cnt[1];
    for (int k = 0; k < 20; k++) begin
      a = i2f(k + 1); b = 32'h4000_0000; in_valid = 1'b1;
      tick();
      if (k == 2) chk("stream_s3_not_yet", 36'(ov3), 36'(0));
      if (k == 3) begin
        chk("stream_s3_first_valid", 36'(ov3), 36'(1));
        chk("stream_s3_first_out", 36'(out3), 36'(32'h4000_0000));
      end
    end
    in_valid = 1'b0;
    repeat (6) tick();
    chk("stream_txn_s3", 36'(cnt3), 36'((base + 20) % 16));

    // ~50% backpressure, 8 beats into the deep instance
    base = m_cnt[1]; n = 0;
    a = rnd_op(); b = rnd_op(); control = 2'($urandom); in_valid = 1'b1;
    for (int t = 0; t < 200 && n < 8; t++) begin
      out_ready = 1'($urandom);
      tick();
      if (acc_q[1]) begin
        n++;
        a = rnd_op(); b = rnd_op(); control = 2'($urandom);
      end
    end
    chk("bp_accepted", 36'(n), 36'(8));
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (8) tick();
    chk("bp_txn_s3", 36'(cnt3), 36'((base + 8) % 16));
    chk("bp_busy_s3", 36'(busy3), 36'(0));

    // overflow beat then 1.0 x 1.0
`ifdef FPMUL_STICKY_FLAGS_EN
    sticky_clr = 1'b1; tick(); sticky_clr = 1'b0;
`endif
    a = 32'h7F00_0000; b = 32'h7F00_0000; control = 2'd0; in_valid = 1'b1;
    tick();
    a = 32'h3F80_0000; b = 32'h3F80_0000;
    tick();
    in_valid = 1'b0;
    chk("ovf_out", 36'(out1), 36'(32'h7F80_0000));
    chk("ovf_flags", 36'(flg1), 36'(4'b0101));
    tick();
    chk("one_out", 36'(out1), 36'(32'h3F80_0000));
    chk("one_flags", 36'(flg1), 36'(0));
`ifdef FPMUL_STICKY_FLAGS_EN
    chk("sticky_set", 36'(stk1), 36'(4'b0101));
    repeat (4) tick();
    sticky_clr = 1'b1; tick(); sticky_clr = 1'b0;
    chk("sticky_cleared", 36'(stk1), 36'(0));
`endif

    // reset with beats in flight
    out_ready = 1'b0; in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin a = rnd_op(); b = rnd_op(); tick(); end
    reset = 1'b1; in_valid = 1'b0;
    tick();
    reset = 1'b0;
    chk("midrst_out_valid", 36'({ov1, ov3}), 36'(0));
    chk("midrst_busy", 36'({busy1, busy3}), 36'(0));
    chk("midrst_txn", 36'({cnt1, cnt3}), 36'(0));
    out_ready = 1'b1;
    repeat (6) tick();

    // 17 handoffs: 4-bit counter wraps to 1
    in_valid = 1'b1;
    for (int k = 0; k < 17; k++) begin a = rnd_op(); b = rnd_op(); control = 2'($urandom); tick(); end
    in_valid = 1'b0;
    repeat (6) tick();
    chk("wrap_txn_s3", 36'(cnt3), 36'(1));
    chk("wrap_txn_s1", 36'(cnt1), 36'(17));

    // random soak
    for (int t = 0; t < 400; t++) begin
      in_valid = 1'($urandom); out_ready = ($urandom_range(0, 3) != 0);
      a = rnd_op(); b = rnd_op(); control = 2'($urandom);
`ifdef FPMUL_STICKY_FLAGS_EN
      sticky_clr = ($urandom_range(0, 7) == 0);
`endif
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1;
`ifdef FPMUL_STICKY_FLAGS_EN
    sticky_clr = 1'b0;
`endif
    repeat (8) tick();
    chk("soak_drained", 36'({busy1, busy3}), 36'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
